// File: rtl/mips_pkg.sv
// Shared MIPS EX-stage definitions: ALU control codes, execution FSM states, default width.
package mips_pkg;

  localparam int unsigned DW_DEFAULT = 32;

  localparam logic [3:0] ALU_ADD = 4'b1000;
  localparam logic [3:0] ALU_SUB = 4'b1001;
  localparam logic [3:0] ALU_AND = 4'b1100;
  localparam logic [3:0] ALU_OR  = 4'b1101;
  localparam logic [3:0] ALU_XOR = 4'b1111;
  localparam logic [3:0] ALU_NOR = 4'b1110;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0000;
  localparam logic [3:0] ALU_SRL = 4'b0010;
  localparam logic [3:0] ALU_SRA = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } exec_state_e;

endpackage

// File: rtl/alu_serial_shifter.sv
// Iterative 1-bit/cycle shifter; done marks the cycle whose step produces the final value.
module alu_serial_shifter
  import mips_pkg::*;
#(
  parameter int unsigned DW  = DW_DEFAULT,
  parameter int unsigned SHW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           dir,
  input  logic           arith,
  input  logic [SHW-1:0] count,
  input  logic [DW-1:0]  data,
  output logic           done,
  output logic [DW-1:0]  value
);

  logic [DW-1:0]  work;
  logic [DW-1:0]  step;
  logic [SHW-1:0] cnt;
  logic           dir_q;
  logic           arith_q;

  // value is the post-step word so the caller can register it on the same edge as the last shift
  always_comb begin
    step  = dir_q ? {arith_q & work[DW-1], work[DW-1:1]} : {work[DW-2:0], 1'b0};
    value = step;
    done  = (cnt == SHW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work    <= '0;
      cnt     <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      work    <= data;
      cnt     <= count;
      dir_q   <= dir;
      arith_q <= arith;
    end else if (cnt != '0) begin
      work <= step;
      cnt  <= cnt - SHW'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle arithmetic/logic, serial shifts, valid/ready on both sides.
// Optional signed-overflow flag enabled by defining ALU_OVERFLOW_EN.
module alu_exec_unit
  import mips_pkg::*;
#(
  parameter int unsigned DW  = DW_DEFAULT,
  parameter int unsigned SHW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     alu_cntrl,
  input  logic [DW-1:0]  src_a,
  input  logic [DW-1:0]  src_b,
  input  logic [SHW-1:0] shamt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  result,
  output logic           zero,
  output logic           illegal,
  output logic           ovf
);

  exec_state_e   state;
  logic          accept;
  logic          is_shift;
  logic          start_shift;
  logic [DW-1:0] alu_res;
  logic          alu_ill;
  logic          sh_done;
  logic [DW-1:0] sh_value;

  assign in_ready    = (state == ST_IDLE) || (state == ST_DONE && out_ready);
  assign accept      = in_valid && in_ready;
  assign is_shift    = (alu_cntrl == ALU_SLL) || (alu_cntrl == ALU_SRL) || (alu_cntrl == ALU_SRA);
  assign start_shift = accept && is_shift && (shamt != '0);

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (alu_cntrl)
      ALU_ADD: alu_res = src_a + src_b;
      ALU_SUB: alu_res = src_a - src_b;
      ALU_AND: alu_res = src_a & src_b;
      ALU_OR:  alu_res = src_a | src_b;
      ALU_XOR: alu_res = src_a ^ src_b;
      ALU_NOR: alu_res = ~(src_a | src_b);
      ALU_SLT: alu_res = {{(DW-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = src_b;
      default: alu_ill = 1'b1;
    endcase
  end

  alu_serial_shifter #(.DW(DW), .SHW(SHW)) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_shift),
    .dir   (alu_cntrl != ALU_SLL),
    .arith (alu_cntrl == ALU_SRA),
    .count (shamt),
    .data  (src_b),
    .done  (sh_done),
    .value (sh_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      if (start_shift) begin
        state     <= ST_SHIFT;
        out_valid <= 1'b0;
      end else begin
        state     <= ST_DONE;
        out_valid <= 1'b1;
        result    <= alu_res;
        zero      <= (alu_res == '0);
        illegal   <= alu_ill;
      end
    end else begin
      case (state)
        ST_SHIFT: if (sh_done) begin
          state     <= ST_DONE;
          out_valid <= 1'b1;
          result    <= sh_value;
          zero      <= (sh_value == '0);
          illegal   <= 1'b0;
        end
        ST_DONE: if (out_ready) begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic ovf_calc;

  always_comb begin
    ovf_calc = 1'b0;
    if (alu_cntrl == ALU_ADD)
      ovf_calc = (src_a[DW-1] == src_b[DW-1]) && (alu_res[DW-1] != src_a[DW-1]);
    else if (alu_cntrl == ALU_SUB)
      ovf_calc = (src_a[DW-1] != src_b[DW-1]) && (alu_res[DW-1] != src_a[DW-1]);
  end

  // shifts clear the flag at accept, so it already reads 0 when their result lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ovf <= 1'b0;
    else if (accept) ovf <= ovf_calc;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized ops vs a behavioural model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_cntrl = 4'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.DW(32), .SHW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_cntrl (alu_cntrl),
    .src_a     (src_a),
    .src_b     (src_b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .ovf       (ovf)
  );

  function automatic bit m_legal(input logic [3:0] op);
    case (op)
      4'b1000, 4'b1001, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b0101,
      4'b0000, 4'b0010, 4'b0001: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_result(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input int sh);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    case (op)
      4'b1000: return a + b;
      4'b1001: return a - b;
      4'b1100: return a & b;
      4'b1101: return a | b;
      4'b1111: return a ^ b;
      4'b1110: return ~(a | b);
      4'b0101: return (sa < sb) ? 32'd1 : 32'd0;
      4'b0000: return b << sh;
      4'b0010: return b >> sh;
      4'b0001: return 32'(sb >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit m_ovf(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_OVERFLOW_EN
    longint s;
    if (op == 4'b1000)      s = longint'($signed(a)) + longint'($signed(b));
    else if (op == 4'b1001) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_latency(input logic [3:0] op, input int sh);
    if (op == 4'b0000 || op == 4'b0010 || op == 4'b0001) return sh + 1;
    return 1;
  endfunction

  // Present one op (DUT assumed ready), scramble inputs after accept, count cycles to out_valid.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int sh, output int lat, output int busy_ready);
    alu_cntrl = op; src_a = a; src_b = b; shamt = 5'(sh);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_cntrl = 4'($urandom); src_a = $urandom; src_b = $urandom; shamt = 5'($urandom);
    lat = 1;
    busy_ready = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ready++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0 || illegal !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b r=%h z=%b i=%b o=%b, want all 0", out_valid, result, zero, illegal, ovf);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_add_ovf();
    int lat, br;
    issue(4'b1000, 32'h7FFF_FFFF, 32'd1, 0, lat, br);
    n_tests++;
    if (lat !== 1 || result !== 32'h8000_0000 || ovf !== m_ovf(4'b1000, 32'h7FFF_FFFF, 32'd1)) begin
      n_fail++;
      $display("FAIL add_ovf: got lat=%0d r=%h ovf=%b, want lat=1 r=80000000 ovf=%b",
               lat, result, ovf, m_ovf(4'b1000, 32'h7FFF_FFFF, 32'd1));
    end
    consume();
  endtask

  task automatic test_sub_slt();
    int lat, br;
    issue(4'b1001, 32'd5, 32'd5, 0, lat, br);
    n_tests++;
    if (result !== 32'd0 || zero !== 1'b1 || lat !== 1) begin
      n_fail++;
      $display("FAIL sub_zero: got r=%h z=%b lat=%0d, want r=0 z=1 lat=1", result, zero, lat);
    end
    consume();
    issue(4'b0101, 32'hFFFF_FFFF, 32'd1, 0, lat, br);
    n_tests++;
    if (result !== 32'd1 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL slt_signed: got r=%h z=%b, want r=1 z=0", result, zero);
    end
    consume();
  endtask

  task automatic test_sra_latency();
    int lat, br;
    issue(4'b0001, 32'd0, 32'h8000_0000, 31, lat, br);
    n_tests++;
    if (lat !== 32 || result !== 32'hFFFF_FFFF || br !== 0) begin
      n_fail++;
      $display("FAIL sra31: got lat=%0d r=%h ready_cycles=%0d, want lat=32 r=ffffffff ready_cycles=0", lat, result, br);
    end
    consume();
  endtask

  task automatic test_sll0_illegal();
    int lat, br;
    issue(4'b0000, 32'hDEAD_BEEF, 32'h1234, 0, lat, br);
    n_tests++;
    if (lat !== 1 || result !== 32'h1234 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL sll0: got lat=%0d r=%h ill=%b, want lat=1 r=00001234 ill=0", lat, result, illegal);
    end
    consume();
    issue(4'b0110, 32'h1111, 32'h2222, 3, lat, br);
    n_tests++;
    if (result !== 32'd0 || illegal !== 1'b1 || zero !== 1'b1 || lat !== 1) begin
      n_fail++;
      $display("FAIL illegal_code: got r=%h ill=%b z=%b lat=%0d, want r=0 ill=1 z=1 lat=1", result, illegal, zero, lat);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat, br;
    int held_bad = 0;
    issue(4'b1101, 32'hF0F0_0000, 32'h0000_0F0F, 0, lat, br);
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || result !== 32'hF0F0_0F0F || in_ready !== 1'b0) held_bad++;
    end
    n_tests++;
    if (held_bad != 0) begin
      n_fail++;
      $display("FAIL hold_stall: got %0d bad cycles (r=%h v=%b rdy=%b), want 0", held_bad, result, out_valid, in_ready);
    end
    out_ready = 1'b1;
    alu_cntrl = 4'b1000; src_a = 32'd100; src_b = 32'd23; in_valid = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b1 || result !== 32'd123) begin
      n_fail++;
      $display("FAIL b2b_add: got v=%b r=%h, want v=1 r=0000007b", out_valid, result);
    end
    alu_cntrl = 4'b1101; src_a = 32'h0000_0F00; src_b = 32'h0000_00F0;
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b1 || result !== 32'h0000_0FF0) begin
      n_fail++;
      $display("FAIL b2b_or: got v=%b r=%h, want v=1 r=00000ff0", out_valid, result);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_drain: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_shift();
    int seen = 0;
    alu_cntrl = 4'b0010; src_a = '0; src_b = 32'hFFFF_0000; shamt = 5'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0 || illegal !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_shift: got v=%b r=%h z=%b i=%b rdy=%b, want 0/0/0/0/1",
               out_valid, result, zero, illegal, in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abandoned_shift: got %0d cycles with output/busy, want 0", seen);
    end
  endtask

  task automatic test_random();
    logic [3:0]  ops [12] = '{4'b1000, 4'b1001, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                              4'b0101, 4'b0000, 4'b0010, 4'b0001, 4'b0011, 4'b1010};
    for (int i = 0; i < 60; i++) begin
      int lat, br, sh;
      logic [3:0]  op;
      logic [31:0] a, b, er;
      op = ops[$urandom_range(0, 11)];
      a  = $urandom;
      b  = $urandom;
      if (i % 7 == 0) b = a;
      sh = int'($urandom_range(0, 31));
      er = m_result(op, a, b, sh);
      issue(op, a, b, sh, lat, br);
      n_tests++;
      if (result !== er || zero !== (er == 32'd0) || illegal !== !m_legal(op) ||
          ovf !== m_ovf(op, a, b) || lat !== m_latency(op, sh) || br !== 0) begin
        n_fail++;
        $display("FAIL random[%0d] op=%b a=%h b=%h sh=%0d: got r=%h z=%b i=%b o=%b lat=%0d, want r=%h z=%b i=%b o=%b lat=%0d",
                 i, op, a, b, sh, result, zero, illegal, ovf, lat,
                 er, er == 32'd0, !m_legal(op), m_ovf(op, a, b), m_latency(op, sh));
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_sub_slt();
    test_sra_latency();
    test_sll0_illegal();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
